uart_mmio_ctrl: RTL

Memory-mapped controller between the RISC-V core's data-memory port and the UART TX/RX cores, occupying UART_BASE (data) and UART_BASE+4 (status/control).
Buffers CPU stores in a small TX FIFO and sequences the UART transmitter with a start/busy handshake.
Holds one received byte with valid and overrun flags, and stalls the core on a store to a full FIFO.
Read data feeds the core's read-data mux alongside data memory.

---
 rtl/uart_mmio_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped bridge between the core's data port and the
// UART TX/RX cores. Data register at UART_BASE and status/control register at
// UART_BASE+4. CPU stores are queued in a small TX FIFO that is drained by a
// start/busy handshake FSM. One received byte is held with valid and overrun
// flags. A store to a full FIFO stalls the core.
module uart_mmio_ctrl #(
  parameter int UART_BASE  = 60,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        stall,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} tx_state_t;

  tx_state_t        state_q, state_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [7:0]       fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       rx_buf_q, rx_buf_d;
  logic             rx_avail_q, rx_avail_d;
  logic             rx_ovr_q, rx_ovr_d;

  logic data_sel;
  logic stat_sel;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic data_load;
  logic unused_wd;

  // Only bits [7:0] (data) and bit 3 (overrun clear) of the store data matter.
  assign unused_wd = &{1'b0, WD[31:8]};

  // Address decode, FIFO status and the handshake strobes shared by all logic.
  always_comb begin
    data_sel  = (Addr == 32'(UART_BASE));
    stat_sel  = (Addr == 32'(UART_BASE + 4));
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    empty     = (count_q == '0);
    stall     = memWrite & data_sel & full;
    push      = memWrite & data_sel & ~full;
    pop       = (state_q == IDLE) & ~empty & ~tx_busy;
    data_load = memRead & data_sel;
  end

  // TX FIFO next state: circular buffer, pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = WD[7:0];
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // TX FSM: launch from IDLE, wait for the transmitter to go busy, then idle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_start_d = 1'b1;
          tx_data_d  = fifo_mem_q[rd_ptr_q];
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RX holding register: a new byte always loads; overrun only when an unread
  // byte is replaced and the core is not reading it in the same cycle.
  always_comb begin
    rx_buf_d   = rx_buf_q;
    rx_avail_d = rx_avail_q;
    rx_ovr_d   = rx_ovr_q;
    if (data_load) begin
      rx_avail_d = 1'b0;
    end
    if (memWrite && stat_sel && WD[3]) begin
      rx_ovr_d = 1'b0;
    end
    if (rx_valid) begin
      rx_buf_d   = rx_data;
      rx_avail_d = 1'b1;
      if (rx_avail_q && !data_load) begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  // Read data mux: registers are visible only during a load of a mapped address.
  always_comb begin
    RD = '0;
    if (memRead) begin
      if (data_sel) begin
        RD = {24'b0, rx_buf_q};
      end else if (stat_sel) begin
        RD[0]         = full;
        RD[1]         = empty;
        RD[2]         = rx_avail_q;
        RD[3]         = rx_ovr_q;
        RD[4 +: CNT_W] = count_q;
      end
    end
  end

  // State registers; reset flushes the FIFO and aborts any launch in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_buf_q   <= '0;
      rx_avail_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_buf_q   <= rx_buf_d;
      rx_avail_q <= rx_avail_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
